registers_access_arbiter: RTL
=============================

Name: registers_access_arbiter

Overview:
- Shares the single-port configuration register bank between two requesters: requester 0 is the host/SPI command path; requester 1 is the internal status updater (e.g. sync-error flag writes).
- Sequences each access through the bank's strobe protocol. readEnable has priority over writeEnable in the bank; readData and writeAck are registered, one cycle after the strobe.
- Inserts the mandatory idle cycle after every write, so the bank clears writeAck and its write-only registers.
- Applies writeAdmin per requester and flags bank write-acknowledge timeouts.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 4, register address width.
- ADMIN_MASK, 2'b10, bit n=1 means requester n writes with writeAdmin=1.
- ACK_TIMEOUT, 4, WAIT cycles allowed for bank writeAck before error (>=1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- req  in  2  per-requester request; held until ack.
- we  in  2  per-requester 1=write, 0=read; valid while req.
- addr0, addr1  in  ADDR_W each  request address.
- wdata0, wdata1  in  DATA_W each  write data.
- ack  out  2  one-cycle completion pulse, one bit per requester.
- rdata  out  DATA_W  read data; valid while the corresponding ack bit is high, held until the next read completes.
- err  out  2  per-requester write-timeout pulse, coincident with ack.
- bank_address  out  ADDR_W  to bank address.
- bank_writeEnable  out  1  to bank writeEnable.
- bank_readEnable  out  1  to bank readEnable.
- bank_writeData  out  DATA_W  to bank writeData.
- bank_writeAdmin  out  1  to bank writeAdmin.
- bank_readData  in  DATA_W  from bank readData.
- bank_writeAck  in  1  from bank writeAck.

Behaviour:
- Reset: state IDLE; ack, err, rdata, all bank_* outputs = 0; round-robin pointer favours requester 0.
- All outputs are registered.
- FSM: IDLE -> ACCESS -> WAIT -> DONE -> IDLE; one transaction in flight at a time.
- IDLE, grant:
  - Sample req at cycle T.
  - If only one bit is set, grant it.
  - If both are set, grant the requester not granted last (round-robin). The pointer updates only on grant.
  - Latch we, addr and wdata of the winner. Go to ACCESS.
- ACCESS (T+1):
  - Exactly one of bank_readEnable/bank_writeEnable is high for exactly this cycle.
  - bank_address and bank_writeData carry the latched values.
  - bank_writeAdmin = ADMIN_MASK[grant] on writes, 0 on reads.
  - Go to WAIT.
- WAIT (T+2), strobes low:
  - Read: capture bank_readData into rdata, go to DONE.
  - Write: go to DONE when bank_writeAck=1, with err=0.
  - Write timeout: if writeAck is absent after ACK_TIMEOUT WAIT cycles, go to DONE with err[grant] set.
- DONE (T+3 nominal):
  - ack[grant]=1 (plus err[grant] if timed out).
  - Bank strobes low; this is the write-recovery cycle.
  - Go to IDLE.
- Throughput: one access per 4 cycles nominal. The next grant is sampled in IDLE at T+4, so a strobe never occurs earlier than T+5.
- Requester protocol:
  - Hold req, we, addr, wdata stable until ack.
  - Deassert req the cycle after ack; otherwise a new transaction starts.
  - Dropping req mid-transaction does not abort it; ack still pulses.
- The non-granted requester waits with req held; no starvation. Worst-case wait is one transaction.
- Bank address is passed through unchecked; out-of-map addresses complete normally (bank defines the data).
- Timeout counter: log2(ACK_TIMEOUT)+1 bits. Clears on ACCESS entry; saturates.
- Reset mid-operation: immediate return to reset values. No ack is issued for the aborted transaction; the bank is reset by the same rstn.

Test Plan:
- Read, single requester: req=2'b01, we=0, addr0=4'h3, bank returns 32'hDEADBEEF.
  -> bank_readEnable high only at T+1 with bank_address=3; ack=2'b01 at T+3; rdata=32'hDEADBEEF.
- Admin write: req=2'b10, we=2'b10, addr1=4'h5, wdata1=32'h1.
  -> bank_writeEnable and bank_writeAdmin high at T+1; ack=2'b10, err=0 at T+3; both bank strobes low at T+3 and T+4.
- Contention: req=2'b11 held continuously, both reads.
  -> grants alternate 0,1,0,1; strobes at T+1, T+5, T+9, T+13; each ack is one cycle.
- Host write: req0 write, addr0=4'h2.
  -> bank_writeAdmin=0; pointer then favours requester 1 when both request.
- Timeout: bank model never asserts writeAck, ACK_TIMEOUT=4, write from requester 0.
  -> ack=2'b01 and err=2'b01 in the same cycle, 4 WAIT cycles after ACCESS; FSM returns to IDLE.
- Reset in WAIT of a write: rstn low for 2 cycles.
  -> all outputs 0 asynchronously; no ack after release; next req0 is granted normally.

Source files
------------

// File: rtl/registers_access_arbiter.sv
// registers_access_arbiter
//   Shares the single-port configuration register bank between two requesters
//   (0 = host/SPI command path, 1 = internal status updater). Each access is
//   sequenced IDLE -> ACCESS -> WAIT -> DONE: one strobe cycle, a wait for the
//   registered bank response, and a recovery cycle that also carries the ack.
//   Simultaneous requests are served round-robin.
// Ports:
//   clk, rstn                  clock (posedge) and async active-low reset
//   req[1:0], we[1:0]          per-requester request / write select
//   addr0/1, wdata0/1          per-requester address and write data
//   ack[1:0], err[1:0]         completion pulse and write-timeout pulse
//   rdata                      last read data, held until the next read ends
//   bank_*                     strobe interface to the register bank
module registers_access_arbiter #(
  parameter int         DATA_W      = 32,
  parameter int         ADDR_W      = 4,
  parameter logic [1:0] ADMIN_MASK  = 2'b10,
  parameter int         ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] bank_address,
  output logic              bank_writeEnable,
  output logic              bank_readEnable,
  output logic [DATA_W-1:0] bank_writeData,
  output logic              bank_writeAdmin,
  input  logic [DATA_W-1:0] bank_readData,
  input  logic              bank_writeAck
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               grant_r, grant_s;   // requester owning the transaction
  logic               last_r, last_s;     // last granted requester (round-robin)
  logic               we_r, we_s;         // latched direction of the transaction
  logic [CNT_W-1:0]   cnt_r, cnt_s;       // WAIT cycles spent on a write
  logic               win_s;
  logic [1:0]         ack_s, err_s;
  logic [DATA_W-1:0]  rdata_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [DATA_W-1:0]  wdata_s;
  logic               ren_s, wen_s, admin_s;

  // Next-state, grant and next-output decode
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    we_s    = we_r;
    cnt_s   = cnt_r;
    win_s   = 1'b0;
    ack_s   = 2'b00;
    err_s   = 2'b00;
    rdata_s = rdata;
    addr_s  = bank_address;
    wdata_s = bank_writeData;
    ren_s   = 1'b0;
    wen_s   = 1'b0;
    admin_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != 2'b00) begin
          // Both requesting: serve the one not granted last time.
          if (req == 2'b11) begin
            win_s = ~last_r;
          end else begin
            win_s = req[1];
          end
          grant_s = win_s;
          last_s  = win_s;
          we_s    = we[win_s];
          addr_s  = win_s ? addr1 : addr0;
          wdata_s = win_s ? wdata1 : wdata0;
          ren_s   = ~we[win_s];
          wen_s   = we[win_s];
          admin_s = we[win_s] & ADMIN_MASK[win_s];
          cnt_s   = {CNT_W{1'b0}};
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (!we_r) begin
          // Bank readData is valid one cycle after the read strobe.
          rdata_s          = bank_readData;
          ack_s[grant_r]   = 1'b1;
          state_s          = DONE;
        end else if (bank_writeAck) begin
          ack_s[grant_r]   = 1'b1;
          state_s          = DONE;
        end else if (cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
          ack_s[grant_r]   = 1'b1;
          err_s[grant_r]   = 1'b1;
          state_s          = DONE;
        end else if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      DONE: begin
        // Strobes stay low here: the bank's write-recovery cycle.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rstn
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r          <= IDLE;
      grant_r          <= 1'b0;
      last_r           <= 1'b1;   // requester 0 wins the first contention
      we_r             <= 1'b0;
      cnt_r            <= {CNT_W{1'b0}};
      ack              <= 2'b00;
      err              <= 2'b00;
      rdata            <= {DATA_W{1'b0}};
      bank_address     <= {ADDR_W{1'b0}};
      bank_writeData   <= {DATA_W{1'b0}};
      bank_readEnable  <= 1'b0;
      bank_writeEnable <= 1'b0;
      bank_writeAdmin  <= 1'b0;
    end else begin
      state_r          <= state_s;
      grant_r          <= grant_s;
      last_r           <= last_s;
      we_r             <= we_s;
      cnt_r            <= cnt_s;
      ack              <= ack_s;
      err              <= err_s;
      rdata            <= rdata_s;
      bank_address     <= addr_s;
      bank_writeData   <= wdata_s;
      bank_readEnable  <= ren_s;
      bank_writeEnable <= wen_s;
      bank_writeAdmin  <= admin_s;
    end
  end

endmodule
